card_dealer: RTL and testbench
==============================

# card_dealer

Draws playing cards from a tracked 52-card deck for the BlackJack game. It is the downstream consumer of the free-running `Counter` output: the instantaneous count value at the moment of a draw request serves as the entropy source. Each request yields one rank (1..13) and its BlackJack point value, never dealing more than four copies of any rank. The deck is restored by `i_Shuffle` or reset. Requests and results come from and go to the game FSM.

## Interface
- `WIDTH`, default 12: width of the count input; must match the `Counter` instance.
- `clk_50M`  in  1  50 MHz system clock; all logic is on its rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Count`  in  WIDTH  free-running count from `Counter`; treated as unsigned.
- `i_Req`  in  1  draw request; its rising edge is the event.
- `i_Shuffle`  in  1  restores the full deck; level, sampled each cycle.
- `o_Card`  out  4  last dealt rank: 1=A, 2..10, 11=J, 12=Q, 13=K.
- `o_Points`  out  4  points of `o_Card`: A=1, 2..10 face value, J/Q/K=10.
- `o_Valid`  out  1  one-cycle pulse; `o_Card` and `o_Points` are updated in the same cycle.
- `o_Busy`  out  1  high while a draw is in progress.
- `o_Empty`  out  1  high when no cards remain.
- `o_Remaining`  out  6  cards left in the deck, 0..52.

## Operation
- Deck state:
  - 13 per-rank counters, 3 bits each, holding 0..4 copies.
  - A 6-bit total counter, kept consistent with the sum of the per-rank counters.
- Request detection:
  - `r_ReqPrev` is a register of `i_Req`; reset value 0.
  - The event is `i_Req & ~r_ReqPrev`.
  - If `i_Req` is held high through reset, this produces an event in the first cycle after reset.
  - Holding `i_Req` high yields only one draw.
- FSM states: IDLE, PROBE.
  - IDLE → PROBE on a request event when `o_Remaining != 0` and `i_Shuffle == 0`.
    - Latch the candidate rank as `(i_Count % 13) + 1`, computed over the full WIDTH bits.
  - IDLE on a request event when `o_Remaining == 0`: the request is ignored. No `o_Valid`, stay in IDLE.
  - PROBE, candidate count != 0 (hit):
    - Decrement the candidate's counter and the total.
    - Load `o_Card` and `o_Points`, set `o_Valid` for one cycle.
    - Go to IDLE.
  - PROBE, candidate count == 0 (miss): advance the candidate to the next rank (13 wraps to 1) and stay in PROBE.
  - A miss cannot repeat more than 12 times, because PROBE is entered only when the total is nonzero.
- Shuffle:
  - When `i_Shuffle` is high in any state, all rank counters become 4, the total becomes 52, and the FSM goes to IDLE.
  - An in-flight draw is aborted with no `o_Valid`.
  - A request event in the same cycle is discarded.
  - `o_Card` and `o_Points` keep their last values.
- `o_Busy` = (state == PROBE).
- `o_Empty` = (total == 0), driven combinationally from the total register.
- Request events during PROBE are ignored; `r_ReqPrev` still tracks `i_Req`.
- Reset values:
  - State IDLE.
  - Every rank counter 4, total 52 (so `o_Remaining = 52`, `o_Empty = 0`).
  - `o_Card = 0`, `o_Points = 0`, `o_Valid = 0`, `o_Busy = 0`, `r_ReqPrev = 0`.
- Reset has priority over shuffle and requests. Reset during PROBE aborts the draw with no `o_Valid`.

## Timing
- Request edge sampled at edge N (state IDLE): PROBE is active in cycle N+1.
- First-probe hit: the hit is registered at edge N+1, so `o_Valid`, `o_Card` and `o_Points` are visible in cycle N+2, and `o_Remaining` is decremented in the same cycle.
- Each miss adds exactly one cycle. Worst case is `o_Valid` in cycle N+14.
- The earliest next accepted request is sampled in the cycle in which `o_Valid` is high, since the state is already IDLE then.
- `i_Count` is sampled only at the accepting edge; later changes have no effect on the draw.

## Test plan
- Reset → `o_Remaining = 52`, `o_Empty = 0`, `o_Card = 0`, `o_Points = 0`, `o_Valid = 0`, `o_Busy = 0`.
- `i_Count = 12` and an `i_Req` pulse → `o_Valid` two cycles after the edge, `o_Card = 13`, `o_Points = 10`, `o_Remaining = 51`. Repeat with `i_Count = 4095` (4095 % 13 = 0) → `o_Card = 1`, `o_Points = 1`.
- Four requests with `i_Count = 0` deal four aces. A fifth request with `i_Count = 0` → `o_Card = 2`, with `o_Valid` three cycles after the edge (one miss).
- Exhaust all kings, then request with `i_Count = 12` → wrap-around, `o_Card = 1`. Also hold `i_Req` high for 10 cycles → exactly one `o_Valid`.
- 52 requests with random `i_Count` → each rank is dealt exactly 4 times and `o_Empty = 1`. A 53rd request → no `o_Valid`, `o_Busy` stays 0.
- Assert `i_Shuffle` during PROBE (after a miss) → no `o_Valid`, state IDLE next cycle, `o_Remaining = 52`. `i_Shuffle` together with a request edge → no draw. Assert `i_Reset` during PROBE → same result, with `o_Card = 0`.

Source files
------------

// File: rtl/card_dealer_if.sv
// Request/result bundle between the BlackJack game FSM and the card dealer.
interface card_dealer_if #(
    parameter int unsigned WIDTH = 12
);
    logic [WIDTH-1:0] i_Count;
    logic             i_Req;
    logic             i_Shuffle;
    logic [3:0]       o_Card;
    logic [3:0]       o_Points;
    logic             o_Valid;
    logic             o_Busy;
    logic             o_Empty;
    logic [5:0]       o_Remaining;

    // Game side: issues requests, consumes dealt cards
    modport master (
        output i_Count, i_Req, i_Shuffle,
        input  o_Card, o_Points, o_Valid, o_Busy, o_Empty, o_Remaining
    );

    // Dealer side
    modport slave (
        input  i_Count, i_Req, i_Shuffle,
        output o_Card, o_Points, o_Valid, o_Busy, o_Empty, o_Remaining
    );
endinterface

// File: rtl/card_dealer.sv
// Deals ranks from a tracked 52-card deck, seeded by the free-running count
// at the request edge; probes upward (wrapping) past exhausted ranks.
module card_dealer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic               clk_50M,
    input  logic               i_Reset,
    card_dealer_if.slave       bus
);
    localparam int unsigned NUM_RANKS = 13;
    localparam int unsigned RANK_W    = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned TOTAL_W   = 6;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] PROBE = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic [RANK_W-1:0]  cand;       // candidate rank index 0..12 (rank - 1)
    logic [RANK_W-1:0]  cand_nxt;
    logic [CNT_W-1:0]   rank_cnt [NUM_RANKS];
    logic [TOTAL_W-1:0] total;
    logic               req_prev;
    logic               req_evt;
    logic               deal;
    logic [RANK_W-1:0]  card_q;
    logic [3:0]         points_q;
    logic               valid_q;
    logic [WIDTH-1:0]   count_mod;

    assign req_evt   = bus.i_Req & ~req_prev;
    assign count_mod = bus.i_Count % WIDTH'(NUM_RANKS);

    // Next state, candidate advance and hit detection
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        deal      = 1'b0;
        if (bus.i_Shuffle) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_evt && (total != TOTAL_W'(0))) begin
                        state_nxt = PROBE;
                        cand_nxt  = RANK_W'(count_mod);
                    end
                end
                PROBE: begin
                    if (rank_cnt[cand] != CNT_W'(0)) begin
                        deal      = 1'b1;
                        state_nxt = IDLE;
                    end else if (cand == RANK_W'(NUM_RANKS - 1)) begin
                        cand_nxt  = RANK_W'(0);
                    end else begin
                        cand_nxt  = cand + RANK_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, deck bookkeeping and registered results
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state    <= IDLE;
            cand     <= RANK_W'(0);
            req_prev <= 1'b0;
            total    <= TOTAL_W'(52);
            card_q   <= 4'd0;
            points_q <= 4'd0;
            valid_q  <= 1'b0;
            for (int i = 0; i < NUM_RANKS; i++) rank_cnt[i] <= CNT_W'(4);
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            req_prev <= bus.i_Req;
            valid_q  <= deal;
            if (bus.i_Shuffle) begin
                total <= TOTAL_W'(52);
                for (int i = 0; i < NUM_RANKS; i++) rank_cnt[i] <= CNT_W'(4);
            end else if (deal) begin
                rank_cnt[cand] <= rank_cnt[cand] - CNT_W'(1);
                total          <= total - TOTAL_W'(1);
                card_q         <= cand + RANK_W'(1);
                points_q       <= (cand >= RANK_W'(9)) ? 4'd10 : cand + 4'd1;
            end
        end
    end

    assign bus.o_Card      = card_q;
    assign bus.o_Points    = points_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Busy      = (state == PROBE);
    assign bus.o_Empty     = (total == TOTAL_W'(0));
    assign bus.o_Remaining = total;
endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer.
`timescale 1ns/1ps
module tb_card_dealer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    card_dealer_if #(.WIDTH(12)) bus ();

    card_dealer #(.WIDTH(12)) dut (
        .clk_50M (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    // Pulse i_Req with the given count; lat = edges after the accepting edge
    // until o_Valid is seen (-1 on timeout). Count is scrambled after acceptance.
    task automatic draw(input logic [11:0] cnt, output int lat,
                        output logic [3:0] card, output logic [3:0] pts);
        lat  = -1;
        card = 4'd0;
        pts  = 4'd0;
        @(negedge clk);
        bus.i_Count = cnt;
        bus.i_Req   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                bus.i_Req   = 1'b0;
                bus.i_Count = ~cnt;
            end
            if (bus.o_Valid) begin
                lat  = k;
                card = bus.o_Card;
                pts  = bus.o_Points;
                break;
            end
        end
    endtask

    task automatic do_shuffle();
        @(negedge clk);
        bus.i_Shuffle = 1'b1;
        @(negedge clk);
        bus.i_Shuffle = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.o_Remaining !== 6'd52) begin n_bad++; $display("FAIL reset_remaining got %0d want 52", bus.o_Remaining); end
        n_cmp++; if (bus.o_Empty !== 1'b0) begin n_bad++; $display("FAIL reset_empty got %b want 0", bus.o_Empty); end
        n_cmp++; if (bus.o_Card !== 4'd0) begin n_bad++; $display("FAIL reset_card got %0d want 0", bus.o_Card); end
        n_cmp++; if (bus.o_Points !== 4'd0) begin n_bad++; $display("FAIL reset_points got %0d want 0", bus.o_Points); end
        n_cmp++; if (bus.o_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.o_Valid); end
        n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.o_Busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [3:0] c, p;
        draw(12'd12, lat, c, p);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL king_latency got %0d want 1", lat); end
        n_cmp++; if (c !== 4'd13) begin n_bad++; $display("FAIL king_card got %0d want 13", c); end
        n_cmp++; if (p !== 4'd10) begin n_bad++; $display("FAIL king_points got %0d want 10", p); end
        n_cmp++; if (bus.o_Remaining !== 6'd51) begin n_bad++; $display("FAIL king_remaining got %0d want 51", bus.o_Remaining); end
        @(posedge clk); #1;
        n_cmp++; if (bus.o_Valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse_width got %b want 0", bus.o_Valid); end
        draw(12'd4095, lat, c, p);
        n_cmp++; if (c !== 4'd1) begin n_bad++; $display("FAIL max_count_card got %0d want 1", c); end
        n_cmp++; if (p !== 4'd1) begin n_bad++; $display("FAIL max_count_points got %0d want 1", p); end
        n_cmp++; if (bus.o_Remaining !== 6'd50) begin n_bad++; $display("FAIL max_count_remaining got %0d want 50", bus.o_Remaining); end
        draw(12'd22, lat, c, p);  // 22 % 13 = 9 -> rank 10
        n_cmp++; if (c !== 4'd10 || p !== 4'd10) begin n_bad++; $display("FAIL ten_card got %0d/%0d want 10/10", c, p); end
        draw(12'd23, lat, c, p);  // 23 % 13 = 10 -> jack
        n_cmp++; if (c !== 4'd11 || p !== 4'd10) begin n_bad++; $display("FAIL jack_card got %0d/%0d want 11/10", c, p); end
    endtask

    task automatic test_aces();
        int lat; logic [3:0] c, p;
        do_shuffle();
        #1;
        n_cmp++; if (bus.o_Remaining !== 6'd52) begin n_bad++; $display("FAIL shuffle_restore got %0d want 52", bus.o_Remaining); end
        for (int i = 0; i < 4; i++) begin
            draw(12'd0, lat, c, p);
            n_cmp++; if (c !== 4'd1 || lat !== 1) begin n_bad++; $display("FAIL ace_%0d got card %0d lat %0d want 1 lat 1", i, c, lat); end
        end
        draw(12'd0, lat, c, p);
        n_cmp++; if (c !== 4'd2 || p !== 4'd2) begin n_bad++; $display("FAIL fifth_ace_card got %0d/%0d want 2/2", c, p); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL fifth_ace_latency got %0d want 2", lat); end
    endtask

    task automatic test_wrap();
        int lat; int nvalid; logic [3:0] c, p;
        do_shuffle();
        for (int i = 0; i < 4; i++) draw(12'd12, lat, c, p);
        draw(12'd12, lat, c, p);
        n_cmp++; if (c !== 4'd1 || lat !== 2) begin n_bad++; $display("FAIL wrap_card got card %0d lat %0d want 1 lat 2", c, lat); end
        n_cmp++; if (bus.o_Remaining !== 6'd47) begin n_bad++; $display("FAIL wrap_remaining got %0d want 47", bus.o_Remaining); end
        nvalid = 0;
        @(negedge clk);
        bus.i_Count = 12'd5;
        bus.i_Req   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.o_Valid) nvalid++;
        end
        bus.i_Req = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus.o_Valid) nvalid++; end
        n_cmp++; if (nvalid !== 1) begin n_bad++; $display("FAIL held_req_valids got %0d want 1", nvalid); end
        n_cmp++; if (bus.o_Card !== 4'd6) begin n_bad++; $display("FAIL held_req_card got %0d want 6", bus.o_Card); end
    endtask

    task automatic test_exhaust();
        int lat; int hist [14]; int bad_pts; int busy_seen; int valid_seen;
        logic [3:0] c, p, exp_p;
        do_shuffle();
        for (int r = 0; r < 14; r++) hist[r] = 0;
        bad_pts = 0;
        for (int i = 0; i < 52; i++) begin
            draw(12'($urandom_range(0, 4095)), lat, c, p);
            if (lat < 0) hist[0]++;
            else begin
                hist[c]++;
                exp_p = (c >= 4'd10) ? 4'd10 : c;
                if (p !== exp_p) bad_pts++;
            end
        end
        n_cmp++; if (hist[0] !== 0) begin n_bad++; $display("FAIL exhaust_timeouts got %0d want 0", hist[0]); end
        n_cmp++; if (bad_pts !== 0) begin n_bad++; $display("FAIL exhaust_points_errors got %0d want 0", bad_pts); end
        for (int r = 1; r <= 13; r++) begin
            n_cmp++; if (hist[r] !== 4) begin n_bad++; $display("FAIL rank_%0d_dealt got %0d want 4", r, hist[r]); end
        end
        n_cmp++; if (bus.o_Empty !== 1'b1) begin n_bad++; $display("FAIL empty_flag got %b want 1", bus.o_Empty); end
        n_cmp++; if (bus.o_Remaining !== 6'd0) begin n_bad++; $display("FAIL empty_remaining got %0d want 0", bus.o_Remaining); end
        busy_seen = 0; valid_seen = 0;
        @(negedge clk);
        bus.i_Count = 12'd3;
        bus.i_Req   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) bus.i_Req = 1'b0;
            if (bus.o_Busy) busy_seen++;
            if (bus.o_Valid) valid_seen++;
        end
        n_cmp++; if (valid_seen !== 0) begin n_bad++; $display("FAIL empty_req_valid got %0d want 0", valid_seen); end
        n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL empty_req_busy got %0d want 0", busy_seen); end
    endtask

    task automatic test_abort();
        int lat; int valid_seen; logic [3:0] c, p;
        do_shuffle();
        for (int i = 0; i < 4; i++) draw(12'd0, lat, c, p);
        // Request ace again: first probe misses, shuffle lands on the hit cycle
        @(negedge clk);
        bus.i_Count = 12'd0; bus.i_Req = 1'b1;
        @(negedge clk);
        bus.i_Req = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.o_Busy !== 1'b1 || bus.o_Valid !== 1'b0) begin n_bad++; $display("FAIL miss_busy got busy %b valid %b want 1 0", bus.o_Busy, bus.o_Valid); end
        @(negedge clk);
        bus.i_Shuffle = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.o_Valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b want 0", bus.o_Valid); end
        n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.o_Busy); end
        n_cmp++; if (bus.o_Remaining !== 6'd52) begin n_bad++; $display("FAIL abort_remaining got %0d want 52", bus.o_Remaining); end
        n_cmp++; if (bus.o_Card !== 4'd1) begin n_bad++; $display("FAIL abort_card_kept got %0d want 1", bus.o_Card); end
        @(negedge clk);
        bus.i_Shuffle = 1'b0;
        // Shuffle coincident with a request edge discards the request
        valid_seen = 0;
        @(negedge clk);
        bus.i_Shuffle = 1'b1; bus.i_Count = 12'd7; bus.i_Req = 1'b1;
        @(posedge clk); #1;
        if (bus.o_Busy) valid_seen++;
        @(negedge clk);
        bus.i_Shuffle = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.o_Busy || bus.o_Valid) valid_seen++;
        end
        bus.i_Req = 1'b0;
        n_cmp++; if (valid_seen !== 0) begin n_bad++; $display("FAIL shuffle_req_draw got %0d active cycles want 0", valid_seen); end
        n_cmp++; if (bus.o_Remaining !== 6'd52) begin n_bad++; $display("FAIL shuffle_req_remaining got %0d want 52", bus.o_Remaining); end
        // Reset during a probe after a miss
        for (int i = 0; i < 4; i++) draw(12'd0, lat, c, p);
        @(negedge clk);
        bus.i_Count = 12'd0; bus.i_Req = 1'b1;
        @(negedge clk);
        bus.i_Req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.o_Valid !== 1'b0 || bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL reset_abort got valid %b busy %b want 0 0", bus.o_Valid, bus.o_Busy); end
        n_cmp++; if (bus.o_Card !== 4'd0 || bus.o_Points !== 4'd0) begin n_bad++; $display("FAIL reset_abort_card got %0d/%0d want 0/0", bus.o_Card, bus.o_Points); end
        n_cmp++; if (bus.o_Remaining !== 6'd52) begin n_bad++; $display("FAIL reset_abort_remaining got %0d want 52", bus.o_Remaining); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; logic [3:0] c, p;
        draw(12'd1, lat, c, p);  // rank 2
        // Next request raised in the o_Valid cycle is accepted immediately
        bus.i_Count = 12'd2; bus.i_Req = 1'b1;  // rank 3
        @(posedge clk); #1;
        bus.i_Req = 1'b0;
        n_cmp++; if (bus.o_Busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", bus.o_Busy); end
        @(posedge clk); #1;
        n_cmp++; if (bus.o_Valid !== 1'b1 || bus.o_Card !== 4'd3) begin n_bad++; $display("FAIL b2b_card got valid %b card %0d want 1 3", bus.o_Valid, bus.o_Card); end
        n_cmp++; if (bus.o_Remaining !== 6'd50) begin n_bad++; $display("FAIL b2b_remaining got %0d want 50", bus.o_Remaining); end
    endtask

    initial begin
        bus.i_Count   = 12'd0;
        bus.i_Req     = 1'b0;
        bus.i_Shuffle = 1'b0;
        test_reset();
        test_basic();
        test_aces();
        test_wrap();
        test_exhaust();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
